// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller:
// bus widths, RISC-V opcodes used by the predictor, FSM states.
package fetch_ctrl_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W_DEF = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_PUSH = 2'd1,
        ST_DROP = 2'd2
    } state_e;

endpackage

// File: rtl/static_bp.sv
// Static predictor: JAL and backward conditional branches are taken.
// target_o is the decoded jump/branch target (pc when not taken).
module static_bp
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              taken_o,
    output logic [ADDR_W-1:0] target_o
);

    logic [6:0]        opc;
    logic              is_jal;
    logic              is_bbr;
    logic [20:0]       j_imm;
    logic [12:0]       b_imm;
    logic [ADDR_W-1:0] off;

    assign opc    = inst_i[6:0];
    assign is_jal = (opc == OPC_JAL);
    assign is_bbr = (opc == OPC_BRANCH) && inst_i[31];

    assign j_imm = {inst_i[31], inst_i[19:12], inst_i[20],
                    inst_i[30:21], 1'b0};
    assign b_imm = {inst_i[31], inst_i[7], inst_i[30:25],
                    inst_i[11:8], 1'b0};

    always_comb begin
        off = '0;
        unique case (1'b1)
            is_jal:  off = {{(ADDR_W-21){j_imm[20]}}, j_imm};
            is_bbr:  off = {{(ADDR_W-13){b_imm[12]}}, b_imm};
            default: off = '0;
        endcase
    end

    assign taken_o  = is_jal | is_bbr;
    assign target_o = pc_i + off;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request,
// holding register towards the instruction queue, static prediction.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_data_i,
    input  logic              iq_full_i,
    output logic              iq_we_o,
    output logic [INST_W-1:0] iq_inst_o,
    output logic [ADDR_W-1:0] iq_pc_o,
    output logic              iq_bp_o,
    output logic              iq_clear_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] hpc_q, hpc_d;
    logic [ADDR_W-1:0] spc_q, spc_d;
    logic [INST_W-1:0] hinst_q, hinst_d;

    logic              bp_taken;
    logic [ADDR_W-1:0] bp_target;
    logic [ADDR_W-1:0] next_pc;
    logic              push_ok;

    static_bp #(
        .ADDR_W (ADDR_W)
    ) u_bp (
        .inst_i   (hinst_q),
        .pc_i     (hpc_q),
        .taken_o  (bp_taken),
        .target_o (bp_target)
    );

    assign next_pc = bp_taken ? bp_target : hpc_q + ADDR_W'(4);

    assign push_ok = (state_q == ST_PUSH) && rdy
                   && !iq_full_i && !redirect_i;

    assign mem_req_o  = (state_q != ST_PUSH);
    assign mem_addr_o = pc_q;
    assign iq_we_o    = push_ok;
    assign iq_inst_o  = hinst_q;
    assign iq_pc_o    = hpc_q;
    assign iq_bp_o    = bp_taken;
    assign iq_clear_o = redirect_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hpc_d   = hpc_q;
        spc_d   = spc_q;
        hinst_d = hinst_q;
        if (rdy) begin
            unique case (state_q)
                ST_REQ: begin
                    if (mem_ack_i) begin
                        if (redirect_i) begin
                            pc_d = redirect_pc_i;
                        end else begin
                            hinst_d = mem_data_i;
                            hpc_d   = pc_q;
                            state_d = ST_PUSH;
                        end
                    end else if (redirect_i) begin
                        // request cannot be aborted; squash its reply
                        spc_d   = redirect_pc_i;
                        state_d = ST_DROP;
                    end
                end
                ST_PUSH: begin
                    if (redirect_i) begin
                        pc_d    = redirect_pc_i;
                        state_d = ST_REQ;
                    end else if (!iq_full_i) begin
                        pc_d    = next_pc;
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (mem_ack_i) begin
                        pc_d    = redirect_i ? redirect_pc_i : spc_q;
                        state_d = ST_REQ;
                    end else if (redirect_i) begin
                        spc_d = redirect_pc_i;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            hpc_q   <= '0;
            spc_q   <= '0;
            hinst_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hpc_q   <= hpc_d;
            spc_q   <= spc_d;
            hinst_q <= hinst_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: prediction table, directed corner sequences,
// and random traffic against a transaction-level reference model.
module tb_fetch_ctrl;

    localparam int AW = 32;
    localparam logic [31:0] RPC = 32'h0;

    logic        clk = 1'b0;
    logic        rst, rdy, redirect_i, mem_ack_i, iq_full_i;
    logic [31:0] redirect_pc_i, mem_data_i;
    logic        mem_req_o, iq_we_o, iq_bp_o, iq_clear_o;
    logic [31:0] mem_addr_o, iq_inst_o, iq_pc_o;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .iq_full_i(iq_full_i), .iq_we_o(iq_we_o),
        .iq_inst_o(iq_inst_o), .iq_pc_o(iq_pc_o),
        .iq_bp_o(iq_bp_o), .iq_clear_o(iq_clear_o)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // reference model: a held instruction or an in-flight request
    bit          m_held, m_sq;
    logic [31:0] m_addr, m_inst, m_ipc, m_spc;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    function automatic logic [32:0] predict(input logic [31:0] inst,
                                            input logic [31:0] pc);
        int off;
        if (inst[6:0] == 7'h6F) begin
            off = int'({inst[31], inst[19:12], inst[20],
                        inst[30:21], 1'b0});
            if (inst[31]) off = off - (1 << 21);
            return {1'b1, pc + 32'(off)};
        end
        if (inst[6:0] == 7'h63 && inst[31]) begin
            off = int'({inst[31], inst[7], inst[30:25],
                        inst[11:8], 1'b0}) - (1 << 13);
            return {1'b1, pc + 32'(off)};
        end
        return {1'b0, pc + 32'd4};
    endfunction

    task automatic step(input bit r, input bit rd, input bit rdr,
                        input logic [31:0] rpc, input bit ack,
                        input logic [31:0] data, input bit full);
        logic [32:0] p;
        @(negedge clk);
        rst = r; rdy = rd; redirect_i = rdr; redirect_pc_i = rpc;
        mem_ack_i = ack; mem_data_i = data; iq_full_i = full;
        #1;
        p = predict(m_inst, m_ipc);
        if (chk_en) begin
            chk("mem_req", 32'(mem_req_o), 32'(!m_held));
            if (!m_held) chk("mem_addr", mem_addr_o, m_addr);
            chk("iq_we", 32'(iq_we_o),
                32'(m_held && !full && !rdr && rd));
            chk("iq_inst", iq_inst_o, m_inst);
            chk("iq_pc", iq_pc_o, m_ipc);
            chk("iq_bp", 32'(iq_bp_o), 32'(p[32]));
            chk("iq_clear", 32'(iq_clear_o), 32'(rdr));
        end
        @(posedge clk);
        if (!r) begin
            m_held = 0; m_sq = 0; m_addr = RPC;
            m_inst = 0; m_ipc = 0; m_spc = 0;
        end else if (rd) begin
            if (m_held) begin
                if (rdr) begin
                    m_held = 0; m_addr = rpc;
                end else if (!full) begin
                    m_held = 0; m_addr = p[31:0];
                end
            end else if (ack) begin
                if (rdr || m_sq) begin
                    m_addr = rdr ? rpc : m_spc;
                    m_sq = 0;
                end else begin
                    m_held = 1; m_inst = data; m_ipc = m_addr;
                end
            end else if (rdr) begin
                m_sq = 1; m_spc = rpc;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          bp;
        logic [31:0] nxt;
    } vec_t;

    vec_t tbl[8];
    logic [31:0] a0;
    logic [31:0] d;
    bit rr, rd, rdr, ack, full;

    initial begin
        tbl[0] = '{32'h0000_0000, 32'h0000_0013, 1'b0, 32'h0000_0004};
        tbl[1] = '{32'h0000_0100, 32'hFE00_0EE3, 1'b1, 32'h0000_00FC};
        tbl[2] = '{32'h0000_0100, 32'h0080_006F, 1'b1, 32'h0000_0108};
        tbl[3] = '{32'h0000_0200, 32'hFF1F_F06F, 1'b1, 32'h0000_01F0};
        tbl[4] = '{32'h0000_0300, 32'h0000_80E7, 1'b0, 32'h0000_0304};
        tbl[5] = '{32'h0000_0300, 32'h0000_0463, 1'b0, 32'h0000_0304};
        tbl[6] = '{32'hFFFF_FFFC, 32'h0080_006F, 1'b1, 32'h0000_0004};
        tbl[7] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'h0000_0000};

        step(0, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        #1;
        chk("rst_req", 32'(mem_req_o), 32'd1);
        chk("rst_addr", mem_addr_o, RPC);
        chk("rst_inst", iq_inst_o, 32'h0);

        // basic fetch: ack after 2 cycles
        idle(2);
        step(1, 1, 0, 0, 1, 32'h13, 0);
        #1;
        chk("f0_we", 32'(iq_we_o), 32'd1);
        chk("f0_pc", iq_pc_o, 32'h0);
        chk("f0_bp", 32'(iq_bp_o), 32'd0);
        idle(1);
        #1;
        chk("f0_next", mem_addr_o, 32'h4);

        // prediction table; redirect+ack moves pc without a write
        foreach (tbl[i]) begin
            step(1, 1, 1, tbl[i].pc, 1, 32'hDEAD_BEEF, 0);
            step(1, 1, 0, 0, 1, tbl[i].inst, 0);
            #1;
            chk($sformatf("t%0d_we", i), 32'(iq_we_o), 32'd1);
            chk($sformatf("t%0d_pc", i), iq_pc_o, tbl[i].pc);
            chk($sformatf("t%0d_bp", i), 32'(iq_bp_o), 32'(tbl[i].bp));
            step(1, 1, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("t%0d_next", i), mem_addr_o, tbl[i].nxt);
        end

        // queue full for 5 cycles in PUSH, then one write
        a0 = mem_addr_o;
        step(1, 1, 0, 0, 1, 32'h0000_0093, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0, 0, 1);
            #1;
            chk("full_inst", iq_inst_o, 32'h0000_0093);
        end
        step(1, 1, 0, 0, 0, 0, 0);
        #1;
        chk("full_rel_we", 32'(iq_we_o), 32'd0);
        chk("full_next", mem_addr_o, a0 + 32'd4);

        // redirect without ack: request continues, reply dropped
        a0 = mem_addr_o;
        step(1, 1, 1, 32'h200, 0, 0, 0);
        idle(2);
        #1;
        chk("drop_addr", mem_addr_o, a0);
        step(1, 1, 0, 0, 1, 32'h0080_006F, 0);
        #1;
        chk("drop_we", 32'(iq_we_o), 32'd0);
        chk("drop_next", mem_addr_o, 32'h200);
        step(1, 1, 1, 32'h280, 0, 0, 0);
        step(1, 1, 1, 32'h300, 0, 0, 0);
        step(1, 1, 0, 0, 1, 32'h13, 0);
        #1;
        chk("drop2_next", mem_addr_o, 32'h300);

        // redirect while holding an instruction
        step(1, 1, 0, 0, 1, 32'h13, 0);
        step(1, 1, 1, 32'h40, 0, 0, 0);
        #1;
        chk("pushrd_next", mem_addr_o, 32'h40);

        // stall across an ack, then reset during DROP
        a0 = mem_addr_o;
        step(1, 1, 1, 32'h500, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h600, 1, 32'h13, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("stall_addr", mem_addr_o, a0);
        step(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst2_req", 32'(mem_req_o), 32'd1);
        chk("rst2_addr", mem_addr_o, RPC);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rr   = ($urandom_range(0, 199) != 0);
            rd   = ($urandom_range(0, 7) != 0);
            rdr  = ($urandom_range(0, 9) == 0);
            ack  = !m_held && ($urandom_range(0, 2) == 0);
            full = ($urandom_range(0, 2) == 0);
            d    = $urandom;
            case ($urandom_range(0, 3))
                0: d[6:0] = 7'h6F;
                1: d[6:0] = 7'h63;
                default: ;
            endcase
            step(rr, rd, rdr, $urandom & 32'hFFFF_FFFC, ack, d, full);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h0, first fetch address after reset; ADDR_W, 32, address/PC width.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  in  1  reset, synchronous, active-low (rst=0 resets on the next clk edge).
REQ-004 rdy  in  1  global ready; 0 freezes all state.
REQ-005 redirect_i  in  1  pipeline flush request (mispredict/jump) from commit.
REQ-006 redirect_pc_i  in  ADDR_W  new fetch PC, valid while redirect_i=1.
REQ-007 mem_req_o  out  1  instruction word request to memory arbiter.
REQ-008 mem_addr_o  out  ADDR_W  word address of request; stable while mem_req_o=1 and no ack.
REQ-009 mem_ack_i  in  1  one-cycle pulse: mem_data_i valid, request complete.
REQ-010 mem_data_i  in  32  fetched instruction word.
REQ-011 iq_full_i  in  1  registered full flag from instruction queue (asserts with >=1 slot still free).
REQ-012 iq_we_o  out  1  queue write strobe.
REQ-013 iq_inst_o  out  32  instruction to queue.
REQ-014 iq_pc_o  out  ADDR_W  PC of iq_inst_o.
REQ-015 iq_bp_o  out  1  static prediction: 1 = predicted taken.
REQ-016 iq_clear_o  out  1  queue flush; combinationally equal to redirect_i.

Function
REQ-017 FSM states SHALL be REQ, PUSH, DROP.
REQ-018 REQ: mem_req_o=1, mem_addr_o=pc; on mem_ack_i with redirect_i=0, SHALL latch mem_data_i and pc into holding regs and go to PUSH.
REQ-019 PUSH: mem_req_o=0; iq_we_o=1 iff iq_full_i=0 and redirect_i=0; on write SHALL set pc to next_pc and go to REQ; otherwise SHALL stay in PUSH holding data.
REQ-020 iq_inst_o, iq_pc_o, iq_bp_o SHALL be driven from holding regs and stable throughout PUSH.
REQ-021 Prediction: opcode 1101111 (JAL) -> taken, target pc+sext(J-imm); opcode 1100011 with inst[31]=1 (backward branch) -> taken, target pc+sext(B-imm); all others incl. JALR -> not taken.
REQ-022 next_pc SHALL be target when taken, else pc+4, modulo 2^ADDR_W (wrap, no error).
REQ-023 Redirect in REQ without same-cycle ack: SHALL save redirect_pc_i and go to DROP; mem_req_o and mem_addr_o SHALL remain unchanged (no abort).
REQ-024 Redirect in REQ with same-cycle ack: data SHALL be discarded, pc=redirect_pc_i, stay REQ with new address next cycle.
REQ-025 DROP: mem_req_o=1 at old address; on ack, data SHALL be discarded, pc=saved PC, go to REQ; further redirects in DROP SHALL overwrite saved PC (latest wins).
REQ-026 Redirect in PUSH: held instruction SHALL be discarded (iq_we_o=0), pc=redirect_pc_i, go to REQ.
REQ-027 iq_we_o SHALL never be 1 in a cycle where redirect_i=1 or rdy=0.
REQ-028 rdy=0: state, pc, holding regs SHALL hold; mem_ack_i and redirect_i SHALL be ignored; mem_req_o/mem_addr_o held; iq_clear_o still follows redirect_i.
REQ-029 Throughput: at most one instruction per 2 cycles plus memory latency; no outstanding request beyond one.

Reset
REQ-030 rst=0 at a clk edge (rdy ignored) SHALL give state=REQ, pc=RESET_PC, holding regs=0, iq_we_o=0, iq_inst_o=0, iq_pc_o=0, iq_bp_o=0.
REQ-031 Reset mid-request SHALL abandon any outstanding fetch; first cycle after release: mem_req_o=1, mem_addr_o=RESET_PC.

Structure
REQ-032 Opcode constants (JAL, BRANCH), state encodings, instruction/address bus widths SHALL live in the shared definitions include.
REQ-033 Prediction/target logic SHALL be one combinational sub-module, static_bp, inputs inst and pc, outputs taken and target.

Verification
REQ-034 Reset, ack after 2 cycles with 32'h00000013 -> mem_addr_o=0, then iq_we_o=1, iq_pc_o=0, iq_bp_o=0; next mem_addr_o=4.
REQ-035 Fetch at 0x100 returns 32'hFE000EE3 (beq x0,x0,-4) -> iq_bp_o=1, next mem_addr_o=0x0FC; 32'h0080006F (jal +8) -> next mem_addr_o=0x108.
REQ-036 iq_full_i=1 for 5 cycles in PUSH -> iq_we_o=0, outputs stable; on release exactly one write.
REQ-037 Redirect to 0x200 in REQ, ack 3 cycles later -> mem_addr_o unchanged until ack, no write, next mem_addr_o=0x200; second redirect to 0x300 in DROP -> 0x300.
REQ-038 Redirect to 0x40 with iq_full_i=0 in PUSH -> iq_we_o=0, iq_clear_o=1 that cycle, next mem_addr_o=0x40.
REQ-039 rdy=0 for 4 cycles across an ack pulse and reset asserted mid-DROP -> no state change while rdy=0; after reset mem_addr_o=RESET_PC.
